level_controller: RTL
=====================

LEVEL_CONTROLLER -- requirements
Module: level_controller

Interface
REQ-001 The module SHALL have parameter NUM_LEVELS, default 15, meaning the total number of levels (minimum 2).
REQ-002 The module SHALL have parameter LEVEL_W, default 4, meaning the width of the level index; it SHALL satisfy 2^LEVEL_W >= NUM_LEVELS.
REQ-003 The module SHALL have parameter PERIOD_W, default 26, meaning the width of the tick period and tick counter.
REQ-004 The module SHALL have parameter BASE_PERIOD, default 25000000, meaning the move-tick period in clocks at level 0.
REQ-005 The module SHALL have parameter PERIOD_STEP, default 1500000, meaning the period reduction in clocks per level.
REQ-006 The module SHALL have parameter MIN_PERIOD, default 2000000, meaning the period floor (minimum 2).
REQ-007 The module SHALL have parameter MAX_BLOCKS, default 3, meaning the block count at level 0.
REQ-008 The module SHALL have parameter BLOCK_DROP_EVERY, default 5, meaning the number of levels per one-block reduction.
REQ-009 The module SHALL have parameter BLOCK_W, default 3, meaning the width of num_blocks.
REQ-010 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-011 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-012 The module SHALL have port go, input, 1 bit, the player start/continue request.
REQ-013 The module SHALL have port level_clear, input, 1 bit, a one-cycle pulse when the current row is placed successfully.
REQ-014 The module SHALL have port fail, input, 1 bit, a one-cycle pulse when a placement misses entirely.
REQ-015 The module SHALL have port level, output, LEVEL_W bits, the current level index (0-based).
REQ-016 The module SHALL have port period, output, PERIOD_W bits, the active move-tick period.
REQ-017 The module SHALL have port num_blocks, output, BLOCK_W bits, the block width for the current level.
REQ-018 The module SHALL have port playing, output, 1 bit, high while in state PLAY.
REQ-019 The module SHALL have port game_won, output, 1 bit, high while in state WON.
REQ-020 The module SHALL have port move_tick, output, 1 bit, a one-cycle pulse that advances the moving row.

Function
REQ-021 The FSM SHALL have three states: WAIT, PLAY and WON.
REQ-022 In WAIT, go SHALL cause a transition to PLAY on the next clock edge; otherwise the FSM stays in WAIT.
REQ-023 In PLAY, fail SHALL set level to 0 and return to WAIT; fail has priority over a simultaneous level_clear.
REQ-024 In PLAY, level_clear with level < NUM_LEVELS-1 SHALL increment level and return to WAIT.
REQ-025 In PLAY, level_clear with level = NUM_LEVELS-1 SHALL go to WON with level held (no wrap).
REQ-026 In WON, go SHALL set level to 0 and move to WAIT; otherwise the FSM stays in WON.
REQ-027 level_clear and fail SHALL be ignored outside PLAY; go SHALL be ignored in PLAY.
REQ-028 period SHALL be combinational from level: max(BASE_PERIOD - level*PERIOD_STEP, MIN_PERIOD), computed without underflow (clamp before subtraction wraps).
REQ-029 num_blocks SHALL be combinational from level: max(MAX_BLOCKS - level/BLOCK_DROP_EVERY, 1), using integer division.
REQ-030 The tick counter SHALL be held at 0 outside PLAY and SHALL be 0 on the first PLAY cycle.
REQ-031 In PLAY, the counter SHALL increment each clock; when it equals period-1, move_tick SHALL be 1 for that cycle and the counter SHALL wrap to 0.
REQ-032 The first move_tick after entering PLAY SHALL occur exactly period cycles after entry; subsequent ticks SHALL be exactly period cycles apart.
REQ-033 move_tick SHALL be 0 in any cycle where the FSM is not in PLAY.
REQ-034 playing and game_won SHALL be registered state decodes with no combinational path from inputs.

Reset
REQ-035 While reset is high at a clock edge, the module SHALL set state WAIT, level 0, tick counter 0, move_tick 0, playing 0 and game_won 0; period and num_blocks then show their level-0 values.
REQ-036 Reset SHALL take priority over all inputs, including mid-PLAY and in WON.

Verification
Bench parameters: NUM_LEVELS=4, BASE_PERIOD=8, PERIOD_STEP=2, MIN_PERIOD=3, MAX_BLOCKS=3, BLOCK_DROP_EVERY=2, PERIOD_W=4.
REQ-037 Reset then go pulse -> playing=1 next cycle, level=0, period=8, num_blocks=3, move_tick on PLAY cycles 8, 16 and 24 (1-based).
REQ-038 Sequence go, level_clear three times through levels 0..3 -> period 8,6,4,3 (clamped), num_blocks 3,3,2,2; the fourth level_clear at level 3 -> game_won=1, level stays 3.
REQ-039 In PLAY at level 2, fail and level_clear asserted together -> WAIT, level=0, move_tick=0.
REQ-040 In WON, go -> WAIT with level=0; a following go -> PLAY with period=8.
REQ-041 Reset asserted mid-PLAY at level 2 with the counter at 3 -> next cycle WAIT, level 0, counter 0, no move_tick.
REQ-042 level_clear or fail pulsed while in WAIT, and go pulsed while in PLAY -> no change to state, level or counter.

Source files
------------

// File: rtl/level_controller.sv
// Level controller: WAIT/PLAY/WON game FSM, per-level move-tick period and
// block width, and the move-tick generator that paces the moving row.
module level_controller #(
  parameter int unsigned NUM_LEVELS       = 15,
  parameter int unsigned LEVEL_W          = 4,
  parameter int unsigned PERIOD_W         = 26,
  parameter int unsigned BASE_PERIOD      = 25000000,
  parameter int unsigned PERIOD_STEP      = 1500000,
  parameter int unsigned MIN_PERIOD       = 2000000,
  parameter int unsigned MAX_BLOCKS       = 3,
  parameter int unsigned BLOCK_DROP_EVERY = 5,
  parameter int unsigned BLOCK_W          = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic                level_clear,
  input  logic                fail,
  output logic [LEVEL_W-1:0]  level,
  output logic [PERIOD_W-1:0] period,
  output logic [BLOCK_W-1:0]  num_blocks,
  output logic                playing,
  output logic                game_won,
  output logic                move_tick
);

  typedef enum logic [1:0] {StWait, StPlay, StWon} state_e;

  state_e              state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                playing_q, game_won_q;
  logic [63:0]         reduction;
  logic [31:0]         drops;
  logic                tick;

  // Period from level, clamped at the floor before the subtraction can wrap.
  always_comb begin
    reduction = 64'(level_q) * 64'(PERIOD_STEP);
    if ((BASE_PERIOD <= MIN_PERIOD) || (reduction >= 64'(BASE_PERIOD - MIN_PERIOD))) begin
      period = PERIOD_W'(MIN_PERIOD);
    end else begin
      period = PERIOD_W'(64'(BASE_PERIOD) - reduction);
    end
  end

  // Block width from level, never below one block.
  always_comb begin
    drops = 32'(level_q) / BLOCK_DROP_EVERY;
    if ((MAX_BLOCKS <= 1) || (drops >= MAX_BLOCKS - 1)) begin
      num_blocks = BLOCK_W'(1);
    end else begin
      num_blocks = BLOCK_W'(MAX_BLOCKS - drops);
    end
  end

  // Tick fires on the last count of each period while playing.
  assign tick = playing_q && (cnt_q == period - PERIOD_W'(1));

  // Next state and level; fail outranks level_clear, inputs ignored where irrelevant.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      StWait: begin
        if (go) state_d = StPlay;
      end
      StPlay: begin
        if (fail) begin
          level_d = '0;
          state_d = StWait;
        end else if (level_clear) begin
          if (level_q == LEVEL_W'(NUM_LEVELS - 1)) begin
            state_d = StWon;
          end else begin
            level_d = level_q + LEVEL_W'(1);
            state_d = StWait;
          end
        end
      end
      StWon: begin
        if (go) begin
          level_d = '0;
          state_d = StWait;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // Counter runs only while staying in PLAY, so every entry starts from zero.
  always_comb begin
    cnt_d = '0;
    if ((state_q == StPlay) && (state_d == StPlay) && !tick) begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  // State, level, counter and registered state decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StWait;
      level_q    <= '0;
      cnt_q      <= '0;
      playing_q  <= 1'b0;
      game_won_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      playing_q  <= (state_d == StPlay);
      game_won_q <= (state_d == StWon);
    end
  end

  assign level     = level_q;
  assign playing   = playing_q;
  assign game_won  = game_won_q;
  assign move_tick = tick;

endmodule
